// File: rtl/highscore_pkg.sv
// Shared types and constants for the high-score sequencer.
//   RES_W     : result width (6 packed BCD digits)
//   NO_RECORD : value held by a record slot that has never been beaten
//   state_t   : sequencer states
//   bcd_ok()  : true when every nibble of a result is a legal BCD digit
package highscore_pkg;

  localparam int RES_W = 24;
  localparam logic [RES_W-1:0] NO_RECORD = 24'h999999;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMP     = 2'd1,
    SHOW_HS = 2'd2
  } state_t;

  function automatic logic bcd_ok(input logic [RES_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < RES_W / 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/highscore_ctrl_hold_timer.sv
// Down-counter that sets how long the high score stays on the display.
//   clk, resetn : clock, synchronous active-low reset
//   load        : load HOLD_CYCLES-1 (takes priority over dec)
//   dec         : decrement by one
//   zero        : count is zero
// Loading HOLD_CYCLES-1 and leaving on the cycle that sees zero gives a
// dwell of exactly HOLD_CYCLES cycles.
module hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000,
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(HOLD_CYCLES - 1);
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/highscore_ctrl.sv
// Score display sequencer: keeps the best (lowest) reaction time of two
// games, drives the high-score mux select and the live/high-score display
// select, and holds the high score on the display after a new record or a
// show request.
//   clk, resetn        : clock, synchronous active-low reset
//   result_valid       : pulse, result_time holds a finished measurement
//   result_time        : reaction time, packed BCD
//   game_sel           : game owning the result / targeted by show/clear
//   show_req, clear_req: pulses, show / clear the record of game_sel
//   hs_game0, hs_game1 : stored records
//   hs_sel, disp_sel   : mux selects (game1 / high score when 1)
//   new_record         : pulse, a record was just written
//   busy               : high in CMP and SHOW_HS
//   dbg_state          : current sequencer state
// Handshake: all request inputs are single-cycle pulses with no ready;
// a pulse arriving where it is ignored (in CMP, or clear in SHOW_HS) is
// dropped, never queued.
module highscore_ctrl
  import highscore_pkg::*;
#(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int TW          = RES_W
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          result_valid,
  input  logic [TW-1:0] result_time,
  input  logic          game_sel,
  input  logic          show_req,
  input  logic          clear_req,
  output logic [TW-1:0] hs_game0,
  output logic [TW-1:0] hs_game1,
  output logic          hs_sel,
  output logic          disp_sel,
  output logic          new_record,
  output logic          busy,
  output state_t        dbg_state
);

  state_t        state, next_state;
  logic [TW-1:0] cand, cand_d;
  logic          cand_g, cand_g_d;
  logic [TW-1:0] hs_game0_d, hs_game1_d;
  logic          hs_sel_d, disp_sel_d, new_record_d, busy_d;
  logic          capture, clear_hit, show_hit, upd;
  logic          timer_load, timer_dec, timer_zero;
  logic [TW-1:0] cand_rec;

  // Packed BCD digits are aligned, so a plain unsigned compare orders them.
  assign cand_rec = cand_g ? hs_game1 : hs_game0;
  assign upd      = (state == CMP) && bcd_ok(cand) && (cand < cand_rec);

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
    .clk    (clk),
    .resetn (resetn),
    .load   (timer_load),
    .dec    (timer_dec),
    .zero   (timer_zero)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cand       <= '0;
      cand_g     <= 1'b0;
      hs_game0   <= TW'(NO_RECORD);
      hs_game1   <= TW'(NO_RECORD);
      hs_sel     <= 1'b0;
      disp_sel   <= 1'b0;
      new_record <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      cand       <= cand_d;
      cand_g     <= cand_g_d;
      hs_game0   <= hs_game0_d;
      hs_game1   <= hs_game1_d;
      hs_sel     <= hs_sel_d;
      disp_sel   <= disp_sel_d;
      new_record <= new_record_d;
      busy       <= busy_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    clear_hit  = 1'b0;
    show_hit   = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (result_valid) begin
          capture    = 1'b1;
          next_state = CMP;
        end else if (clear_req) begin
          clear_hit  = 1'b1;
        end else if (show_req) begin
          show_hit   = 1'b1;
          next_state = SHOW_HS;
        end
      end
      CMP: begin
        next_state = upd ? SHOW_HS : IDLE;
      end
      SHOW_HS: begin
        if (result_valid) begin
          capture    = 1'b1;
          next_state = CMP;
        end else if (show_req) begin
          show_hit   = 1'b1;
        end else if (timer_zero) begin
          next_state = IDLE;
        end else begin
          timer_dec  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    timer_load = show_hit || upd;
  end

  // Output next-values; selects follow the state being entered so the
  // registered outputs line up with the registered state.
  always_comb begin
    cand_d       = cand;
    cand_g_d     = cand_g;
    hs_game0_d   = hs_game0;
    hs_game1_d   = hs_game1;
    hs_sel_d     = hs_sel;
    new_record_d = 1'b0;
    disp_sel_d   = (next_state == SHOW_HS);
    busy_d       = (next_state != IDLE);
    if (capture) begin
      cand_d   = result_time;
      cand_g_d = game_sel;
    end
    if (clear_hit) begin
      if (game_sel) hs_game1_d = TW'(NO_RECORD);
      else          hs_game0_d = TW'(NO_RECORD);
    end
    if (show_hit) hs_sel_d = game_sel;
    if (upd) begin
      if (cand_g) hs_game1_d = cand;
      else        hs_game0_d = cand;
      hs_sel_d     = cand_g;
      new_record_d = 1'b1;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_highscore_ctrl.sv
// Directed bench for highscore_ctrl with an 8-cycle hold.
module tb_highscore_ctrl;
  import highscore_pkg::*;

  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        result_valid;
  logic [23:0] result_time;
  logic        game_sel;
  logic        show_req;
  logic        clear_req;
  logic [23:0] hs_game0, hs_game1;
  logic        hs_sel, disp_sel, new_record, busy;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  int dcnt, ncnt;

  highscore_ctrl #(.HOLD_CYCLES(HOLD), .TW(24)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .result_valid (result_valid),
    .result_time  (result_time),
    .game_sel     (game_sel),
    .show_req     (show_req),
    .clear_req    (clear_req),
    .hs_game0     (hs_game0),
    .hs_game1     (hs_game1),
    .hs_sel       (hs_sel),
    .disp_sel     (disp_sel),
    .new_record   (new_record),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs set before tick are sampled at its edge; outputs read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_result(input logic g, input logic [23:0] t);
    result_valid = 1'b1;
    result_time  = t;
    game_sel     = g;
    tick();
    result_valid = 1'b0;
  endtask

  // Counts display-on cycles (and new_record pulses) until disp_sel drops.
  task automatic run_hold(output int d, output int n);
    int guard;
    d = 0;
    n = 0;
    guard = 0;
    while (disp_sel && guard < 30) begin
      d++;
      if (new_record) n++;
      tick();
      guard++;
    end
  endtask

  initial begin
    resetn       = 1'b0;
    result_valid = 1'b0;
    result_time  = '0;
    game_sel     = 1'b0;
    show_req     = 1'b0;
    clear_req    = 1'b0;
    repeat (3) tick();

    // 1: reset values
    check("rst_hs0", hs_game0, 24'h999999);
    check("rst_hs1", hs_game1, 24'h999999);
    check("rst_disp", disp_sel, 1'b0);
    check("rst_hssel", hs_sel, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, IDLE);
    resetn = 1'b1;
    tick();

    // 2: first record on game 0
    send_result(1'b0, 24'h000350);
    check("t2_cmp_busy", busy, 1'b1);
    check("t2_n1_hs0", hs_game0, 24'h999999);
    check("t2_n1_nr", new_record, 1'b0);
    tick();
    check("t2_n2_hs0", hs_game0, 24'h000350);
    check("t2_n2_nr", new_record, 1'b1);
    check("t2_n2_sel", hs_sel, 1'b0);
    run_hold(dcnt, ncnt);
    check("t2_dwell", dcnt, HOLD);
    check("t2_nr_pulses", ncnt, 1);
    check("t2_end_busy", busy, 1'b0);

    // 3: tie and worse result leave the record alone
    send_result(1'b0, 24'h000350);
    tick();
    check("t3_tie_hs0", hs_game0, 24'h000350);
    check("t3_tie_nr", new_record, 1'b0);
    check("t3_tie_disp", disp_sel, 1'b0);
    send_result(1'b0, 24'h000400);
    tick();
    check("t3_worse_hs0", hs_game0, 24'h000350);
    check("t3_worse_nr", new_record, 1'b0);
    check("t3_worse_disp", disp_sel, 1'b0);
    check("t3_worse_busy", busy, 1'b0);

    // 4: invalid BCD rejected, then valid record on game 1
    send_result(1'b1, 24'h0003A0);
    tick();
    check("t4_bad_hs1", hs_game1, 24'h999999);
    check("t4_bad_nr", new_record, 1'b0);
    send_result(1'b1, 24'h000210);
    tick();
    check("t4_hs1", hs_game1, 24'h000210);
    check("t4_sel", hs_sel, 1'b1);
    check("t4_hs0_kept", hs_game0, 24'h000350);
    check("t4_disp", disp_sel, 1'b1);

    // 5: abort the hold with 3 cycles left
    repeat (5) tick();
    check("t5_still_disp", disp_sel, 1'b1);
    send_result(1'b0, 24'h000100);
    check("t5_abort_disp", disp_sel, 1'b0);
    check("t5_abort_busy", busy, 1'b1);
    tick();
    check("t5_hs0", hs_game0, 24'h000100);
    check("t5_hs1_kept", hs_game1, 24'h000210);
    check("t5_sel", hs_sel, 1'b0);
    run_hold(dcnt, ncnt);
    check("t5_dwell", dcnt, HOLD);
    check("t5_nr_pulses", ncnt, 1);

    // 6a: clear beats show in IDLE
    clear_req = 1'b1;
    show_req  = 1'b1;
    game_sel  = 1'b0;
    tick();
    clear_req = 1'b0;
    show_req  = 1'b0;
    check("t6_clr_hs0", hs_game0, 24'h999999);
    check("t6_clr_hs1", hs_game1, 24'h000210);
    check("t6_clr_disp", disp_sel, 1'b0);
    check("t6_clr_busy", busy, 1'b0);

    // 6b: show game 1, clear ignored while showing, restart on show game 0
    show_req = 1'b1;
    game_sel = 1'b1;
    tick();
    show_req = 1'b0;
    check("t6_show_disp", disp_sel, 1'b1);
    check("t6_show_sel", hs_sel, 1'b1);
    check("t6_show_nr", new_record, 1'b0);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("t6_clr_ign", hs_game1, 24'h000210);
    repeat (2) tick();
    show_req = 1'b1;
    game_sel = 1'b0;
    tick();
    show_req = 1'b0;
    check("t6_restart_sel", hs_sel, 1'b0);
    run_hold(dcnt, ncnt);
    check("t6_restart_dwell", dcnt, HOLD);
    check("t6_restart_nr", ncnt, 0);

    // 6c: reset mid-hold
    send_result(1'b1, 24'h000050);
    tick();
    check("t6_pre_hs1", hs_game1, 24'h000050);
    tick();
    resetn = 1'b0;
    tick();
    check("t6_rst_hs0", hs_game0, 24'h999999);
    check("t6_rst_hs1", hs_game1, 24'h999999);
    check("t6_rst_sel", hs_sel, 1'b0);
    check("t6_rst_disp", disp_sel, 1'b0);
    check("t6_rst_nr", new_record, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_state", dbg_state, IDLE);
    resetn = 1'b1;
    tick();
    send_result(1'b0, 24'h000999);
    tick();
    check("t6_post_hs0", hs_game0, 24'h000999);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
